// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: feeds one external full-adder slice LSB first,
// collecting sum, carry, overflow, zero and all-propagate flags over WIDTH cycles.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             prop_all,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c_in,
    input  logic             fa_s,
    input  logic             fa_c_out,
    input  logic             fa_p,
    input  logic             fa_g
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             prop_q, prop_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    // The slice's generate output carries no information beyond fa_c_out.
    logic unused_fa_g;
    assign unused_fa_g = fa_g;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        count_d = count_q;
        carry_d = carry_q;
        prop_d  = prop_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        fa_a    = 1'b0;
        fa_b    = 1'b0;
        fa_c_in = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B once here and seed carry-in.
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    carry_d = sub;
                    count_d = '0;
                    prop_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                fa_a    = a_sh_q[0];
                fa_b    = b_sh_q[0];
                fa_c_in = carry_q;
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_c_out;
                prop_d  = prop_q & fa_p;
                count_d = count_q + CW'(1);
                if (count_q == LAST) begin
                    // Overflow: carry into the sign bit differs from carry out of it.
                    c_out_d = fa_c_out;
                    ovf_d   = carry_q ^ fa_c_out;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            prop_q  <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            carry_q <= carry_d;
            prop_q  <= prop_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign c_out    = c_out_q;
    assign ovf      = ovf_q;
    assign zero     = (sum_q == '0);
    assign prop_all = prop_q;

endmodule
